// File: rtl/debounce_scheduler_if.sv
// Pin-side bundle for debounce_scheduler: raw switches in, debounced levels/ticks out.
// DEBOUNCE_RELEASE_TICK_EN adds the rel_tick vector.
interface debounce_scheduler_if #(
    parameter int NCH = 4
);
    logic [NCH-1:0]         sw;
    logic [NCH-1:0]         db_level;
    logic [NCH-1:0]         db_tick;
    logic [$clog2(NCH)-1:0] cur_ch;
`ifdef DEBOUNCE_RELEASE_TICK_EN
    logic [NCH-1:0]         rel_tick;

    modport master (output sw, input db_level, input db_tick, input cur_ch, input rel_tick);
    modport slave  (input sw, output db_level, output db_tick, output cur_ch, output rel_tick);
`else
    modport master (output sw, input db_level, input db_tick, input cur_ch);
    modport slave  (input sw, output db_level, output db_tick, output cur_ch);
`endif
endinterface

// File: rtl/debounce_scheduler.sv
// Shared-prescaler, round-robin debouncer: one channel is sampled per 2^PRESC_BITS clocks.
// Optional macro DEBOUNCE_RELEASE_TICK_EN adds a one-clock release pulse per channel.
module debounce_scheduler #(
    parameter int NCH        = 4,
    parameter int PRESC_BITS = 16,
    parameter int CNT_BITS   = 3
) (
    input  logic clk,
    input  logic reset,
    debounce_scheduler_if.slave bus
);
    localparam int CW = $clog2(NCH);

    typedef enum logic [1:0] {
        ZERO  = 2'd0,
        WAIT1 = 2'd1,
        ONE   = 2'd2,
        WAIT0 = 2'd3
    } state_t;

    logic [NCH-1:0]               sync1_q, s_q;
    logic [PRESC_BITS-1:0]        presc_q;
    logic [CW-1:0]                cur_q;
    logic                         slot;
    state_t                       st_q [NCH];
    state_t                       st_d [NCH];
    logic [NCH-1:0][CNT_BITS-1:0] cnt_q, cnt_d;
    logic [NCH-1:0]               level_q, tick_q, rise_d;
`ifdef DEBOUNCE_RELEASE_TICK_EN
    logic [NCH-1:0]               rel_q, fall_d;
`endif

    assign slot = &presc_q;

    // Only the channel under cur_q can move; everything else holds.
    always_comb begin
        st_d   = st_q;
        cnt_d  = cnt_q;
        rise_d = '0;
`ifdef DEBOUNCE_RELEASE_TICK_EN
        fall_d = '0;
`endif
        for (int i = 0; i < NCH; i++) begin
            if (slot && (cur_q == CW'(i))) begin
                case (st_q[i])
                    ZERO: begin
                        if (s_q[i]) begin
                            st_d[i]  = WAIT1;
                            cnt_d[i] = '1;
                        end
                    end
                    WAIT1: begin
                        if (s_q[i]) begin
                            cnt_d[i] = cnt_q[i] - CNT_BITS'(1);
                            if (cnt_q[i] == CNT_BITS'(1)) begin
                                st_d[i]   = ONE;
                                rise_d[i] = 1'b1;
                            end
                        end else begin
                            st_d[i] = ZERO;
                        end
                    end
                    ONE: begin
                        if (!s_q[i]) begin
                            st_d[i]  = WAIT0;
                            cnt_d[i] = '1;
                        end
                    end
                    WAIT0: begin
                        if (!s_q[i]) begin
                            cnt_d[i] = cnt_q[i] - CNT_BITS'(1);
                            if (cnt_q[i] == CNT_BITS'(1)) begin
                                st_d[i] = ZERO;
`ifdef DEBOUNCE_RELEASE_TICK_EN
                                fall_d[i] = 1'b1;
`endif
                            end
                        end else begin
                            st_d[i] = ONE;
                        end
                    end
                    default: st_d[i] = ZERO;
                endcase
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync1_q <= '0;
            s_q     <= '0;
            presc_q <= '0;
            cur_q   <= '0;
            cnt_q   <= '0;
            level_q <= '0;
            tick_q  <= '0;
            for (int i = 0; i < NCH; i++) st_q[i] <= ZERO;
`ifdef DEBOUNCE_RELEASE_TICK_EN
            rel_q   <= '0;
`endif
        end else begin
            sync1_q <= bus.sw;
            s_q     <= sync1_q;
            presc_q <= presc_q + PRESC_BITS'(1);
            if (slot) cur_q <= (cur_q == CW'(NCH-1)) ? '0 : cur_q + CW'(1);
            st_q    <= st_d;
            cnt_q   <= cnt_d;
            tick_q  <= rise_d;
            for (int i = 0; i < NCH; i++) level_q[i] <= (st_d[i] == ONE) || (st_d[i] == WAIT0);
`ifdef DEBOUNCE_RELEASE_TICK_EN
            rel_q   <= fall_d;
`endif
        end
    end

    assign bus.db_level = level_q;
    assign bus.db_tick  = tick_q;
    assign bus.cur_ch   = cur_q;
`ifdef DEBOUNCE_RELEASE_TICK_EN
    assign bus.rel_tick = rel_q;
`endif
endmodule

// File: tb/tb_debounce_scheduler.sv
// Directed bench for debounce_scheduler (NCH=4 and NCH=3 instances, PRESC_BITS=2, CNT_BITS=2).
// Expected ticks are queued when stimulus is applied and popped by a tick monitor.
module tb_debounce_scheduler;
    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    debounce_scheduler_if #(.NCH(4)) b4();
    debounce_scheduler_if #(.NCH(3)) b3();

    debounce_scheduler #(.NCH(4), .PRESC_BITS(2), .CNT_BITS(2)) dut4 (.clk(clk), .reset(reset), .bus(b4));
    debounce_scheduler #(.NCH(3), .PRESC_BITS(2), .CNT_BITS(2)) dut3 (.clk(clk), .reset(reset), .bus(b3));

    // id: 0 = dut4 press tick, 1 = dut3 press tick, 2 = dut4 release tick
    typedef struct {
        int id;
        int ch;
        int at;
    } tick_t;

    tick_t sb[$];
    int n_tests = 0;
    int n_fail  = 0;
    int edge_n  = 0;

    always @(posedge clk or posedge reset)
        if (reset) edge_n <= 0;
        else       edge_n <= edge_n + 1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic expect_tick(input int id, input int ch, input int at);
        tick_t e;
        e.id = id; e.ch = ch; e.at = at;
        sb.push_back(e);
    endtask

    task automatic pop_tick(input int id, input int ch);
        tick_t e;
        e.id = -1; e.ch = -1; e.at = -1;
        if (sb.size() > 0) e = sb.pop_front();
        n_tests++;
        assert (e.id == id && e.ch == ch && e.at == edge_n) else begin
            n_fail++;
            $error("FAIL tick: got dut%0d ch%0d edge %0d expected dut%0d ch%0d edge %0d",
                   id, ch, edge_n, e.id, e.ch, e.at);
        end
    endtask

    always @(negedge clk) begin
        if (!reset) begin
            for (int c = 0; c < 4; c++) if (b4.db_tick[c]) pop_tick(0, c);
            for (int c = 0; c < 3; c++) if (b3.db_tick[c]) pop_tick(1, c);
`ifdef DEBOUNCE_RELEASE_TICK_EN
            for (int c = 0; c < 4; c++) if (b4.rel_tick[c]) pop_tick(2, c);
`endif
            if (b4.db_tick != '0) chk("tick_onehot", 32'($countones(b4.db_tick)), 1);
        end
    end

    // Returns on the falling edge following rising edge k (counted from reset release).
    task automatic wait_edge(input int k);
        int guard;
        guard = 0;
        while (edge_n < k && guard < 2000) begin
            @(negedge clk);
            guard++;
        end
        if (guard >= 2000) chk("wait_bound", edge_n, k);
    endtask

    task automatic do_reset(input logic [3:0] s4, input logic [2:0] s3);
        reset = 1'b1;
        b4.sw = s4;
        b3.sw = s3;
        repeat (2) @(negedge clk);
        reset = 1'b0;
    endtask

    initial begin
        int s_e, k;
        b4.sw = '0;
        b3.sw = '0;
        repeat (3) @(negedge clk);
        chk("rst_level", b4.db_level, 0);
        chk("rst_tick", b4.db_tick, 0);
        chk("rst_cur", b4.cur_ch, 0);
        chk("rst_level3", b3.db_level, 0);

        // channel 0 held pressed: services at 4/20/36/52
        expect_tick(0, 0, 52);
        do_reset(4'b0001, 3'b000);
        wait_edge(4);   chk("p1_cur_step", b4.cur_ch, 1);
        wait_edge(51);  chk("p1_lvl51", b4.db_level, 4'b0000);
        wait_edge(52);  chk("p1_lvl52", b4.db_level, 4'b0001);
        wait_edge(53);  chk("p1_tick_off", b4.db_tick, 0);
        wait_edge(60);  chk("p1_sb_empty", sb.size(), 0);

        // dropout seen by the service at 36 restarts the count
        expect_tick(0, 0, 100);
        do_reset(4'b0001, 3'b000);
        wait_edge(29);  b4.sw[0] = 1'b0;
        wait_edge(35);  b4.sw[0] = 1'b1;
        wait_edge(99);  chk("p2_lvl99", b4.db_level, 4'b0000);
        wait_edge(100); chk("p2_lvl100", b4.db_level, 4'b0001);
        wait_edge(104); chk("p2_sb_empty", sb.size(), 0);

        // channel 2 press then release; release has no db_tick
        expect_tick(0, 2, 60);
`ifdef DEBOUNCE_RELEASE_TICK_EN
        expect_tick(2, 2, 124);
`endif
        do_reset(4'b0100, 3'b000);
        wait_edge(60);  chk("p3_lvl60", b4.db_level, 4'b0100);
        wait_edge(62);  b4.sw[2] = 1'b0;
        wait_edge(123); chk("p3_lvl123", b4.db_level, 4'b0100);
        wait_edge(124); chk("p3_lvl124", b4.db_level, 4'b0000);
        wait_edge(128); chk("p3_sb_empty", sb.size(), 0);

        // reset while channel 1 sits in WAIT1 with counter 1
        expect_tick(0, 0, 52);
        do_reset(4'b0011, 3'b000);
        wait_edge(52);  chk("p4_pre_lvl", b4.db_level, 4'b0001);
        #2 reset = 1'b1;
        #1;
        chk("p4_rst_lvl", b4.db_level, 0);
        chk("p4_rst_tick", b4.db_tick, 0);
        chk("p4_rst_cur", b4.cur_ch, 0);
`ifdef DEBOUNCE_RELEASE_TICK_EN
        chk("p4_rst_rel", b4.rel_tick, 0);
`endif
        expect_tick(0, 0, 52);
        expect_tick(0, 1, 56);
        repeat (2) @(negedge clk);
        reset = 1'b0;
        wait_edge(55);  chk("p4_lvl55", b4.db_level, 4'b0001);
        wait_edge(56);  chk("p4_lvl56", b4.db_level, 4'b0011);
        wait_edge(60);  chk("p4_sb_empty", sb.size(), 0);

        // 1-clock glitches on sw[3]; hits on alternate services only (services at 16n)
        do_reset(4'b0000, 3'b000);
        for (int i = 0; i < 10; i++) begin
            s_e = 32 + 16 * i;
            if (i % 2 == 0) k = s_e - 3;
            else            k = s_e - 3 - int'($urandom_range(1, 10));
            wait_edge(k);
            b4.sw[3] = 1'b1;
            @(negedge clk);
            b4.sw[3] = 1'b0;
            wait_edge(s_e + 1);
            chk("p5_glitch_lvl", b4.db_level, 0);
        end
        chk("p5_sb_empty", sb.size(), 0);

        // NCH=3: round-robin wrap and three staggered ticks
        expect_tick(1, 0, 40);
        expect_tick(1, 1, 44);
        expect_tick(1, 2, 48);
        do_reset(4'b0000, 3'b111);
        for (int e = 1; e <= 16; e++) begin
            wait_edge(e);
            chk("p6_cur3", b3.cur_ch, (e / 4) % 3);
        end
        wait_edge(47);  chk("p6_lvl47", b3.db_level, 3'b011);
        wait_edge(48);  chk("p6_lvl48", b3.db_level, 3'b111);
        wait_edge(52);  chk("p6_sb_empty", sb.size(), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
